// File: rtl/i2s_player.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2s_player                                                    |
// | Brief    : I2S transmitter; buffers samples in a FIFO and serializes     |
// |            them MSB-first on DACDAT, slaved to a codec-driven BCLK/LRCK. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module i2s_player #(
    parameter int WIDTH      = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic                          i_stop,
    input  logic                          i_BCLK,
    input  logic                          i_LRCK,
    input  logic signed [WIDTH-1:0]       i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_DACDAT,
    output logic                          o_playing,
    output logic                          o_underflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_BW = $clog2(WIDTH + 1);
    localparam logic [c_AW:0]   c_FULL_LEVEL = FIFO_DEPTH[c_AW:0];
    localparam logic [c_BW-1:0] c_BITS_FULL  = WIDTH[c_BW-1:0];

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_PLAY = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;

    logic             r_bclk_meta, r_bclk_sync, r_bclk_prev;
    logic             r_lrck_meta, r_lrck_sync, r_lrck_last;

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]    r_level;

    logic [WIDTH-1:0] r_hold;
    logic [c_BW-1:0]  r_bits_left;
    logic [c_BW-1:0]  w_bit_sel;
    logic             r_dacdat;
    logic             r_underflow;

    logic w_fall, w_lr_edge, w_left_start;
    logic w_full, w_empty, w_push, w_pop, w_pop_ok;

    // Codec BCLK rests high between bits; a falling event is the shift point
    assign w_fall       = r_bclk_prev & ~r_bclk_sync;
    assign w_lr_edge    = w_fall && (r_lrck_sync != r_lrck_last);
    assign w_left_start = w_lr_edge && !r_lrck_sync;

    assign w_full   = (r_level == c_FULL_LEVEL);
    assign w_empty  = (r_level == '0);
    assign o_ready  = (r_state != c_S_IDLE) && !w_full;
    assign w_push   = i_valid && o_ready && !i_stop;
    assign w_pop    = w_left_start && (r_state != c_S_IDLE) && !i_stop;
    assign w_pop_ok = w_pop && !w_empty;
    assign w_bit_sel = r_bits_left - 1'b1;

    assign o_DACDAT     = r_dacdat;
    assign o_playing    = (r_state == c_S_PLAY);
    assign o_underflow  = r_underflow;
    assign o_fifo_level = r_level;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: if (i_start)      w_state_next = c_S_WAIT;
            c_S_WAIT: if (w_left_start) w_state_next = c_S_PLAY;
            c_S_PLAY: w_state_next = c_S_PLAY;
            default:  w_state_next = c_S_IDLE;
        endcase
        if (i_stop) begin
            w_state_next = c_S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_stop || (r_state == c_S_IDLE)) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bclk_meta <= 1'b0;
            r_bclk_sync <= 1'b0;
            r_bclk_prev <= 1'b0;
            r_lrck_meta <= 1'b0;
            r_lrck_sync <= 1'b0;
            r_lrck_last <= 1'b0;
        end else begin
            r_bclk_meta <= i_BCLK;
            r_bclk_sync <= r_bclk_meta;
            r_bclk_prev <= r_bclk_sync;
            r_lrck_meta <= i_LRCK;
            r_lrck_sync <= r_lrck_meta;
            if (w_fall) begin
                r_lrck_last <= r_lrck_sync;
            end
        end
    end

    // Serializer: one idle bit after each LRCK change, then WIDTH bits, then zeros
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold      <= '0;
            r_bits_left <= '0;
            r_dacdat    <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_stop || (r_state == c_S_IDLE) ||
                ((r_state == c_S_WAIT) && !w_left_start)) begin
                r_dacdat    <= 1'b0;
                r_bits_left <= '0;
            end else if (w_fall) begin
                if (w_lr_edge) begin
                    r_dacdat    <= 1'b0;
                    r_bits_left <= c_BITS_FULL;
                end else if (r_bits_left != '0) begin
                    r_dacdat    <= r_hold[w_bit_sel];
                    r_bits_left <= w_bit_sel;
                end else begin
                    r_dacdat <= 1'b0;
                end
            end

            if (i_start) begin
                r_underflow <= 1'b0;
            end
            if (w_pop) begin
                if (w_empty) begin
                    r_hold      <= '0;
                    r_underflow <= 1'b1;
                end else begin
                    r_hold <= r_mem[r_rd_ptr];
                end
            end
        end
    end

endmodule
`default_nettype wire
